// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, optional first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, sticky error flags and flush.
module fifo_flex #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_rd_ok;
    logic w_wr_ok;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_rd_ok = rd & (r_count != '0);
    assign w_wr_ok = wr & ((r_count != CW'(DEPTH)) | w_rd_ok);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (wr & ~w_wr_ok) r_overflow  <= 1'b1;
            if (rd & ~w_rd_ok) r_underflow <= 1'b1;
        end
    end

    // Storage is never cleared; reset and flush only discard it via the pointers.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                  r_rd_data <= '0;
                else if (!flush && w_rd_ok) r_rd_data <= r_mem[r_rd_ptr];
            end
            assign rd_data = r_rd_data;
        end
    endgenerate

    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign full         = (r_count == CW'(DEPTH));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the next generation of the team's generic FIFO. Adds arbitrary (non-power-of-2) depth, a selectable first-word-fall-through read mode, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer logic in the same clock domain and is a drop-in buffer wherever the older FIFO was used.

## Interface
- DATA_WIDTH, 32: word width in bits, ≥1.
- DEPTH, 8: number of entries, any integer ≥2 (power of 2 not required).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- CW (localparam): $clog2(DEPTH+1).

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous clear of contents and error flags.
- wr  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd  in  1  read request (standard) / pop acknowledge (FWFT).
- rd_data  out  DATA_WIDTH  read word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count ≤ AE_LEVEL.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was dropped.

## Operation
- Storage: DEPTH×DATA_WIDTH array; wr_ptr, rd_ptr range 0..DEPTH-1, increment and wrap DEPTH-1 → 0 explicitly (no modulo-2^n reliance).
- count is a registered CW-bit occupancy counter; empty/full/almost_* decode combinationally from count only.
- Accept rules, evaluated per cycle on pre-edge state:
  - rd_ok = rd & (count != 0).
  - wr_ok = wr & ((count != DEPTH) | rd_ok): a write to a full FIFO is accepted when a read pops in the same cycle.
  - wr & rd with count == 0: write accepted, read dropped.
- count update: +1 if wr_ok & !rd_ok; −1 if rd_ok & !wr_ok; unchanged otherwise. Never exceeds DEPTH or goes below 0.
- wr & !wr_ok sets overflow; rd & !rd_ok sets underflow. Both stay set until reset or flush.
- Standard mode (FWFT=0): on rd_ok, rd_data ← mem[rd_ptr] at the edge; otherwise rd_data holds its value.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] continuously, valid whenever empty=0; rd_ok advances rd_ptr so the next word appears after the edge. Contents while empty are don't-care.
- flush: highest priority below reset. wr_ptr, rd_ptr and count go to 0 and overflow/underflow clear. wr/rd in the same cycle are ignored and set no flags. rd_data is not cleared in standard mode.
- reset (async): pointers 0, count 0, rd_data 0, overflow 0, underflow 0. Memory contents are not cleared. Reset mid-burst discards all stored data.

## Timing
- Reset outputs: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0.
- Write-to-flag latency: 1 cycle. count/empty/full reflect a write at the edge that accepts it.
- Standard read latency: rd asserted in cycle N gives data on rd_data after edge N (visible in cycle N+1).
- FWFT: a word written into an empty FIFO at edge N appears on rd_data in cycle N+1 with empty=0.
- Error flags assert at the edge of the offending cycle.
- Sustained wr&rd at any occupancy 1..DEPTH gives one word per cycle with count constant.
- No combinational path from wr/rd to any output except in FWFT mode, where rd_data depends only on registered rd_ptr.

## Test plan
- Reset/fill (DEPTH=5, FWFT=0): write 0x11..0x55 on 5 consecutive cycles -> count steps 1..5, full=1 after 5th edge, almost_full=1 from count=4, overflow=0.
- Wrap and order (DEPTH=5): write 7 words interleaved with reads, reading all -> rd_data sequence matches write order across pointer wrap 4→0, final count=0, empty=1.
- Boundary simultaneity (DEPTH=5): full, wr&rd with wr_data=0xAA -> count stays 5, overflow=0, 0xAA read out as 5th word later. Empty, wr&rd -> count=1, underflow=1.
- Errors/flush: wr when full -> overflow=1 and data dropped. Then flush with wr=1 -> count=0, empty=1, overflow=0, and the write is not stored.
- FWFT (FWFT=1, DEPTH=3): write 0x5 -> next cycle rd_data=0x5, empty=0. Pulse rd -> empty=1, count=0, no underflow.
- Async reset mid-operation: assert reset between edges with count=3 -> count=0, empty=1, rd_data=0 immediately, without waiting for a clock edge.
